psg_envelope_generator: RTL and testbench

//  AY-3-8913 envelope generator for the PSG top level. It consumes R11/R12 (envelope period) and R13 (shape), and

---
 rtl/psg_envelope_generator.sv | 150 +++++++++++++++
 tb/tb_psg_envelope_generator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/psg_envelope_generator.sv
// AY-3-8913 envelope generator: prescaler, period counter, step counter and hold/alternate control.
// Optional 32-step (YM2149) ramps are enabled by defining PSG_ENVELOPE_32STEP_EN.
module psg_envelope_generator #(
  parameter int PRESCALER_BITS = 4,
  parameter int PERIOD_BITS    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   restart,
  input  logic [PERIOD_BITS-1:0] period,
  input  logic                   shape_continue,
  input  logic                   shape_attack,
  input  logic                   shape_alternate,
  input  logic                   shape_hold,
  output logic [4:0]             envelope,
  output logic                   holding,
  output logic                   step_strobe
);

`ifdef PSG_ENVELOPE_32STEP_EN
  localparam int S_BITS = 5;
`else
  localparam int S_BITS = 4;
`endif
  localparam logic [S_BITS-1:0] MAX = {S_BITS{1'b1}};
  localparam int PS_W = (PRESCALER_BITS == 0) ? 1 : PRESCALER_BITS;
  localparam int PW1  = PERIOD_BITS + 1;

  logic [PS_W-1:0]        presc_q, presc_d;
  logic [PERIOD_BITS-1:0] pcnt_q, pcnt_d;
  logic [S_BITS-1:0]      s_q, s_d;
  logic                   phase_up_q, phase_up_d;
  logic                   holding_q, holding_d;
  logic [S_BITS-1:0]      hold_level_q, hold_level_d;
  logic                   step_strobe_q, step_strobe_d;

  logic                   tick_s;
  logic [PW1-1:0]         pcnt_inc_s;
  logic [PW1-1:0]         period_eff_s;
  logic                   step_ev_s;
  logic [S_BITS-1:0]      l_end_s;
  logic [S_BITS-1:0]      lvl_s;

  // Tick and step-event detection; a period of 0 is treated as 1.
  always_comb begin
    tick_s       = 1'b0;
    period_eff_s = {1'b0, period};
    if (PRESCALER_BITS == 0) begin
      tick_s = 1'b1;
    end else begin
      tick_s = (presc_q == {PS_W{1'b1}});
    end
    if (period == {PERIOD_BITS{1'b0}}) begin
      period_eff_s = PW1'(1);
    end else begin
      period_eff_s = {1'b0, period};
    end
    pcnt_inc_s = {1'b0, pcnt_q} + PW1'(1);
    step_ev_s  = tick_s && (pcnt_inc_s >= period_eff_s);
  end

  // Next-state logic for counters and the hold/alternate machine; restart wins over a step.
  always_comb begin
    presc_d       = presc_q + PS_W'(1);
    pcnt_d        = pcnt_q;
    s_d           = s_q;
    phase_up_d    = phase_up_q;
    holding_d     = holding_q;
    hold_level_d  = hold_level_q;
    step_strobe_d = step_ev_s;
    l_end_s       = phase_up_q ? MAX : {S_BITS{1'b0}};

    if (step_ev_s) begin
      pcnt_d = {PERIOD_BITS{1'b0}};
    end else if (tick_s) begin
      pcnt_d = pcnt_inc_s[PERIOD_BITS-1:0];
    end else begin
      pcnt_d = pcnt_q;
    end

    if (step_ev_s && !holding_q) begin
      if (s_q != MAX) begin
        s_d = s_q + S_BITS'(1);
      end else begin
        case ({shape_continue, shape_hold})
          2'b11: begin
            holding_d    = 1'b1;
            hold_level_d = shape_alternate ? (MAX - l_end_s) : l_end_s;
          end
          2'b10: begin
            s_d        = {S_BITS{1'b0}};
            phase_up_d = phase_up_q ^ shape_alternate;
          end
          default: begin
            holding_d    = 1'b1;
            hold_level_d = {S_BITS{1'b0}};
          end
        endcase
      end
    end else begin
      s_d = s_q;
    end

    if (restart) begin
      presc_d       = {PS_W{1'b0}};
      pcnt_d        = {PERIOD_BITS{1'b0}};
      s_d           = {S_BITS{1'b0}};
      holding_d     = 1'b0;
      phase_up_d    = shape_attack;
      step_strobe_d = 1'b0;
    end else begin
      step_strobe_d = step_ev_s;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q       <= {PS_W{1'b0}};
      pcnt_q        <= {PERIOD_BITS{1'b0}};
      s_q           <= {S_BITS{1'b0}};
      phase_up_q    <= 1'b0;
      holding_q     <= 1'b0;
      hold_level_q  <= {S_BITS{1'b0}};
      step_strobe_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      pcnt_q        <= pcnt_d;
      s_q           <= s_d;
      phase_up_q    <= phase_up_d;
      holding_q     <= holding_d;
      hold_level_q  <= hold_level_d;
      step_strobe_q <= step_strobe_d;
    end
  end

  // Output level decode straight from registered state.
  always_comb begin
    lvl_s = holding_q ? hold_level_q : (phase_up_q ? s_q : (MAX - s_q));
`ifdef PSG_ENVELOPE_32STEP_EN
    envelope = lvl_s[4:0];
`else
    envelope = {lvl_s[3:0], lvl_s[3]};
`endif
  end

  assign holding     = holding_q;
  assign step_strobe = step_strobe_q;

endmodule

// File: tb/tb_psg_envelope_generator.sv
// Directed bench for psg_envelope_generator (default 16-step build).
module tb_psg_envelope_generator;

  logic        clk;
  logic        reset;
  logic        restart;
  logic [15:0] period;
  logic [3:0]  shape;
  logic [4:0]  envelope;
  logic        holding;
  logic        step_strobe;

  logic        p_restart;
  logic [15:0] p_period;
  logic [3:0]  p_shape;
  logic [4:0]  p_envelope;
  logic        p_holding;
  logic        p_strobe;

  int n_vec;
  int n_miss;
  int cnt;

  // Falling-ramp levels after the 4-to-5 bit mapping, index = step number.
  logic [4:0] dec_t [16];

  psg_envelope_generator #(.PRESCALER_BITS(0), .PERIOD_BITS(16)) dut (
    .clk(clk), .reset(reset), .restart(restart), .period(period),
    .shape_continue(shape[3]), .shape_attack(shape[2]),
    .shape_alternate(shape[1]), .shape_hold(shape[0]),
    .envelope(envelope), .holding(holding), .step_strobe(step_strobe)
  );

  psg_envelope_generator #(.PRESCALER_BITS(4), .PERIOD_BITS(16)) dut_p (
    .clk(clk), .reset(reset), .restart(p_restart), .period(p_period),
    .shape_continue(p_shape[3]), .shape_attack(p_shape[2]),
    .shape_alternate(p_shape[1]), .shape_hold(p_shape[0]),
    .envelope(p_envelope), .holding(p_holding), .step_strobe(p_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    dec_t = '{5'd31, 5'd29, 5'd27, 5'd25, 5'd23, 5'd21, 5'd19, 5'd17,
              5'd14, 5'd12, 5'd10, 5'd8,  5'd6,  5'd4,  5'd2,  5'd0};
    reset     = 1'b1;
    restart   = 1'b0;
    period    = 16'd1;
    shape     = 4'h0;
    p_restart = 1'b0;
    p_period  = 16'd3;
    p_shape   = 4'hA;
    step();
    step();
    chk("reset_env", 32'(envelope), 32'd31);
    chk("reset_holding", 32'(holding), 32'd0);
    chk("reset_strobe", 32'(step_strobe), 32'd0);
    chk("reset_env_p", 32'(p_envelope), 32'd31);
    reset = 1'b0;

    // Shape 0: decay one step per clock, then hold at 0.
    shape = 4'h0; period = 16'd1; restart = 1'b1;
    step();
    restart = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("s0_ramp", 32'(envelope), 32'(dec_t[k]));
      if (k > 0) chk("s0_strobe", 32'(step_strobe), 32'd1);
      step();
    end
    for (int k = 0; k < 5; k++) begin
      chk("s0_hold_flag", 32'(holding), 32'd1);
      chk("s0_hold_env", 32'(envelope), 32'd0);
      step();
    end

    // Shape A, period 2: triangle, one step every two clocks.
    shape = 4'hA; period = 16'd2; restart = 1'b1;
    step();
    restart = 1'b0;
    for (int c = 0; c < 70; c++) begin
      int j;
      j = (c / 2) % 32;
      chk("sA_tri", 32'(envelope), (j < 16) ? 32'(dec_t[j]) : 32'(dec_t[31 - j]));
      chk("sA_noh", 32'(holding), 32'd0);
      step();
    end

    // Shape D: attack then hold 31, strobe keeps pulsing.
    shape = 4'hD; period = 16'd1; restart = 1'b1;
    step();
    restart = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("sD_ramp", 32'(envelope), 32'(dec_t[15 - k]));
      step();
    end
    for (int k = 0; k < 4; k++) begin
      chk("sD_hold_flag", 32'(holding), 32'd1);
      chk("sD_hold_env", 32'(envelope), 32'd31);
      chk("sD_strobe", 32'(step_strobe), 32'd1);
      step();
    end

    // Shape B: decay then hold 31.
    shape = 4'hB; restart = 1'b1;
    step();
    restart = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("sB_ramp", 32'(envelope), 32'(dec_t[k]));
      step();
    end
    chk("sB_hold_flag", 32'(holding), 32'd1);
    chk("sB_hold_env", 32'(envelope), 32'd31);

    // Shape 8 with period 0 behaves like period 1: saw down every clock.
    shape = 4'h8; period = 16'd0; restart = 1'b1;
    step();
    restart = 1'b0;
    for (int c = 0; c < 40; c++) begin
      chk("s8_p0_saw", 32'(envelope), 32'(dec_t[c % 16]));
      chk("s8_p0_noh", 32'(holding), 32'd0);
      step();
    end

    // Prescaler 4, period 3: a step every 48 clocks.
    p_restart = 1'b1;
    step();
    p_restart = 1'b0;
    chk("p_env_start", 32'(p_envelope), 32'd31);
    cnt = 0;
    while (!p_strobe && cnt < 200) begin
      step();
      cnt++;
    end
    chk("p_first_step_clocks", 32'(cnt), 32'd48);
    chk("p_env_after_step", 32'(p_envelope), 32'd29);
    step();
    cnt = 1;
    while (!p_strobe && cnt < 200) begin
      step();
      cnt++;
    end
    chk("p_second_step_clocks", 32'(cnt), 32'd48);
    chk("p_env_after_step2", 32'(p_envelope), 32'd27);

    // Shape C: restart coincident with the step from s=7 discards that step.
    shape = 4'hC; period = 16'd1; restart = 1'b1;
    step();
    restart = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk("sC_ramp", 32'(envelope), 32'(dec_t[15 - k]));
      step();
    end
    chk("sC_at_s7", 32'(envelope), 32'd14);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("sC_restart_env", 32'(envelope), 32'd0);
    chk("sC_restart_noh", 32'(holding), 32'd0);
    step();
    chk("sC_after_restart", 32'(envelope), 32'd2);

    // Reset overrides a simultaneous restart with attack set.
    shape = 4'hD; restart = 1'b1; reset = 1'b1;
    step();
    chk("reset_over_restart_env", 32'(envelope), 32'd31);
    chk("reset_over_restart_noh", 32'(holding), 32'd0);
    chk("reset_over_restart_strobe", 32'(step_strobe), 32'd0);
    reset = 1'b0; restart = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
